// File: rtl/raster_core.sv
// Per-pixel triangle rasteriser: snapshots a two-polygon scene at frame start,
// then tests each pixel against both triangles with edge functions. Latency 3, 1 pixel/clk.
module raster_core #(
  parameter int XW = 7,
  parameter int YW = 6,
  parameter int CW = 6,
  parameter int DW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start_in,
  input  logic            px_valid_in,
  input  logic [XW-1:0]   px_x_in,
  input  logic [YW-1:0]   px_y_in,
  input  logic [CW-1:0]   bg_color_in,
  input  logic [2*CW-1:0] poly_color_in,
  input  logic [2*XW-1:0] v0_x_in,
  input  logic [2*XW-1:0] v1_x_in,
  input  logic [2*XW-1:0] v2_x_in,
  input  logic [2*YW-1:0] v0_y_in,
  input  logic [2*YW-1:0] v1_y_in,
  input  logic [2*YW-1:0] v2_y_in,
  input  logic [2*DW-1:0] poly_depth_in,
  input  logic            en_screen_in,
  input  logic [1:0]      poly_enable_in,
  output logic [CW-1:0]   color_out,
  output logic            color_valid_out
);

  localparam int EW = XW + YW + 3;

  // Handshake: px_valid_in qualifies px_x_in/px_y_in for one cycle; there is no
  // ready, every valid pixel is accepted and reappears as color_valid_out 3 cycles later.

  // E(a,b,p) = (p.x-a.x)*(b.y-a.y) - (p.y-a.y)*(b.x-a.x), exact in EW signed bits
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [XW-1:0] ax, input logic [YW-1:0] ay,
    input logic [XW-1:0] bx, input logic [YW-1:0] by,
    input logic [XW-1:0] px, input logic [YW-1:0] py
  );
    logic signed [XW:0]   dpx, dbx;
    logic signed [YW:0]   dpy, dby;
    logic signed [EW-1:0] t0, t1;
    dpx = $signed({1'b0, px}) - $signed({1'b0, ax});
    dbx = $signed({1'b0, bx}) - $signed({1'b0, ax});
    dpy = $signed({1'b0, py}) - $signed({1'b0, ay});
    dby = $signed({1'b0, by}) - $signed({1'b0, ay});
    t0 = $signed({{(EW-XW-1){dpx[XW]}}, dpx}) * $signed({{(EW-YW-1){dby[YW]}}, dby});
    t1 = $signed({{(EW-YW-1){dpy[YW]}}, dpy}) * $signed({{(EW-XW-1){dbx[XW]}}, dbx});
    return t0 - t1;
  endfunction

  logic [CW-1:0]   bg_q;
  logic [2*CW-1:0] pcol_q;
  logic [2*XW-1:0] v0x_q, v1x_q, v2x_q;
  logic [2*YW-1:0] v0y_q, v1y_q, v2y_q;
  logic [2*DW-1:0] dep_q;
  logic            en_q;
  logic [1:0]      pen_q;
  logic [1:0]      degen_q;
  logic            setup_q;
  logic            setup_busy;

  assign setup_busy = frame_start_in | setup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_q    <= '0;
      pcol_q  <= '0;
      v0x_q   <= '0;
      v1x_q   <= '0;
      v2x_q   <= '0;
      v0y_q   <= '0;
      v1y_q   <= '0;
      v2y_q   <= '0;
      dep_q   <= '0;
      en_q    <= 1'b0;
      pen_q   <= '0;
      setup_q <= 1'b0;
    end else begin
      setup_q <= frame_start_in;
      if (frame_start_in) begin
        bg_q   <= bg_color_in;
        pcol_q <= poly_color_in;
        v0x_q  <= v0_x_in;
        v1x_q  <= v1_x_in;
        v2x_q  <= v2_x_in;
        v0y_q  <= v0_y_in;
        v1y_q  <= v1_y_in;
        v2y_q  <= v2_y_in;
        dep_q  <= poly_depth_in;
        en_q   <= en_screen_in;
        pen_q  <= poly_enable_in;
      end
    end
  end

  // Zero-area triangles are flagged once per frame, in the cycle after capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      degen_q <= 2'b11;
    end else if (setup_q) begin
      for (int i = 0; i < 2; i++) begin
        degen_q[i] <= (edge_fn(v0x_q[i*XW +: XW], v0y_q[i*YW +: YW],
                               v1x_q[i*XW +: XW], v1y_q[i*YW +: YW],
                               v2x_q[i*XW +: XW], v2y_q[i*YW +: YW]) == '0);
      end
    end
  end

  // S1: register pixel
  logic          s1_valid, s1_busy;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_busy  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= px_valid_in;
      s1_busy  <= setup_busy;
      s1_x     <= px_x_in;
      s1_y     <= px_y_in;
    end
  end

  // S2: three edge functions per polygon
  logic                 s2_valid, s2_busy;
  logic signed [EW-1:0] e_q [2][3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_busy  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 3; k++) e_q[i][k] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      s2_busy  <= s1_busy;
      for (int i = 0; i < 2; i++) begin
        e_q[i][0] <= edge_fn(v0x_q[i*XW +: XW], v0y_q[i*YW +: YW],
                             v1x_q[i*XW +: XW], v1y_q[i*YW +: YW], s1_x, s1_y);
        e_q[i][1] <= edge_fn(v1x_q[i*XW +: XW], v1y_q[i*YW +: YW],
                             v2x_q[i*XW +: XW], v2y_q[i*YW +: YW], s1_x, s1_y);
        e_q[i][2] <= edge_fn(v2x_q[i*XW +: XW], v2y_q[i*YW +: YW],
                             v0x_q[i*XW +: XW], v0y_q[i*YW +: YW], s1_x, s1_y);
      end
    end
  end

  // S3: inside test accepts either winding; zero edges count as inside
  logic [1:0]    hit;
  logic [CW-1:0] color_next;

  always_comb begin
    hit = 2'b00;
    for (int i = 0; i < 2; i++) begin
      hit[i] = pen_q[i] & ~degen_q[i] &
               (((e_q[i][0] >= 0) & (e_q[i][1] >= 0) & (e_q[i][2] >= 0)) |
                ((e_q[i][0] <= 0) & (e_q[i][1] <= 0) & (e_q[i][2] <= 0)));
    end
  end

  always_comb begin
    color_next = bg_q;
    if (!en_q || s2_busy) begin
      color_next = '0;
    end else if (hit == 2'b11) begin
      color_next = (dep_q[DW +: DW] < dep_q[0 +: DW]) ? pcol_q[CW +: CW] : pcol_q[0 +: CW];
    end else if (hit[0]) begin
      color_next = pcol_q[0 +: CW];
    end else if (hit[1]) begin
      color_next = pcol_q[CW +: CW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_valid_out <= 1'b0;
      color_out       <= '0;
    end else begin
      color_valid_out <= s2_valid;
      if (s2_valid) color_out <= color_next;
    end
  end

endmodule

// File: tb/tb_raster_core.sv
// Directed bench for raster_core: hand-computed colours for hits, winding, depth,
// degenerate/disabled scenes, snapshot timing, setup blanking, streaming and reset.
module tb_raster_core;

  localparam int XW = 7, YW = 6, CW = 6, DW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_start_in = 1'b0;
  logic            px_valid_in = 1'b0;
  logic [XW-1:0]   px_x_in = '0;
  logic [YW-1:0]   px_y_in = '0;
  logic [CW-1:0]   bg_color_in = '0;
  logic [2*CW-1:0] poly_color_in = '0;
  logic [2*XW-1:0] v0_x_in = '0, v1_x_in = '0, v2_x_in = '0;
  logic [2*YW-1:0] v0_y_in = '0, v1_y_in = '0, v2_y_in = '0;
  logic [2*DW-1:0] poly_depth_in = '0;
  logic            en_screen_in = 1'b0;
  logic [1:0]      poly_enable_in = '0;
  logic [CW-1:0]   color_out;
  logic            color_valid_out;

  int n_vec = 0;
  int n_err = 0;
  logic [CW-1:0] exp_q[$];

  raster_core #(.XW(XW), .YW(YW), .CW(CW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start_in(frame_start_in),
    .px_valid_in(px_valid_in), .px_x_in(px_x_in), .px_y_in(px_y_in),
    .bg_color_in(bg_color_in), .poly_color_in(poly_color_in),
    .v0_x_in(v0_x_in), .v1_x_in(v1_x_in), .v2_x_in(v2_x_in),
    .v0_y_in(v0_y_in), .v1_y_in(v1_y_in), .v2_y_in(v2_y_in),
    .poly_depth_in(poly_depth_in), .en_screen_in(en_screen_in),
    .poly_enable_in(poly_enable_in), .color_out(color_out),
    .color_valid_out(color_valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_poly(input int i, input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input logic [CW-1:0] col,
                          input logic [DW-1:0] dep);
    v0_x_in[i*XW +: XW] = XW'(x0);
    v0_y_in[i*YW +: YW] = YW'(y0);
    v1_x_in[i*XW +: XW] = XW'(x1);
    v1_y_in[i*YW +: YW] = YW'(y1);
    v2_x_in[i*XW +: XW] = XW'(x2);
    v2_y_in[i*YW +: YW] = YW'(y2);
    poly_color_in[i*CW +: CW] = col;
    poly_depth_in[i*DW +: DW] = dep;
  endtask

  task automatic frame();
    @(negedge clk); frame_start_in = 1'b1;
    @(negedge clk); frame_start_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [CW-1:0] exp);
    @(negedge clk);
    px_valid_in = 1'b1; px_x_in = XW'(x); px_y_in = YW'(y);
    @(negedge clk); px_valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_v"}, 8'(color_valid_out), 8'd1);
    chk({tag, "_c"}, 8'(color_out), 8'(exp));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_v", 8'(color_valid_out), 8'd0);
    chk("rst_c", 8'(color_out), 8'd0);
    rst_n = 1'b1;

    // Basic hit / miss / vertex
    bg_color_in = 6'b000011; en_screen_in = 1'b1; poly_enable_in = 2'b01;
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'b110000, 3'd2);
    frame();
    pix("hit", 20, 20, 6'b110000);
    pix("miss", 60, 30, 6'b000011);
    pix("vertex", 10, 10, 6'b110000);

    // Reverse winding
    set_poly(0, 10, 10, 10, 40, 50, 10, 6'b110000, 3'd2);
    frame();
    pix("winding", 20, 20, 6'b110000);

    // Depth resolution
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'b110000, 3'd2);
    set_poly(1, 10, 10, 50, 10, 10, 40, 6'b001100, 3'd1);
    poly_enable_in = 2'b11;
    frame();
    pix("depth_closer", 20, 20, 6'b001100);
    poly_depth_in[DW +: DW] = 3'd2;
    frame();
    pix("depth_tie", 20, 20, 6'b110000);
    poly_enable_in = 2'b10;
    frame();
    pix("poly1_only", 20, 20, 6'b001100);

    // Degenerate poly0: pixel on the line would otherwise satisfy all E == 0
    set_poly(0, 5, 5, 10, 10, 15, 15, 6'b110000, 3'd2);
    poly_enable_in = 2'b01;
    frame();
    pix("degen", 10, 10, 6'b000011);

    // Screen disabled
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'b110000, 3'd2);
    en_screen_in = 1'b0;
    frame();
    pix("scr_off_in", 20, 20, 6'b000000);
    pix("scr_off_out", 60, 30, 6'b000000);

    // Snapshot: mid-frame colour change invisible until the next frame start
    en_screen_in = 1'b1;
    frame();
    poly_color_in[0 +: CW] = 6'b111111;
    pix("snap_hold", 20, 20, 6'b110000);
    frame();
    pix("snap_new", 20, 20, 6'b111111);
    poly_color_in[0 +: CW] = 6'b110000;

    // Pixels in the frame_start cycle and the setup cycle are blanked
    @(negedge clk);
    frame_start_in = 1'b1; px_valid_in = 1'b1; px_x_in = 7'd20; px_y_in = 6'd20;
    @(negedge clk); frame_start_in = 1'b0;
    @(negedge clk); px_valid_in = 1'b0;
    @(negedge clk);
    chk("busy0_v", 8'(color_valid_out), 8'd1);
    chk("busy0_c", 8'(color_out), 8'd0);
    @(negedge clk);
    chk("busy1_v", 8'(color_valid_out), 8'd1);
    chk("busy1_c", 8'(color_out), 8'd0);
    pix("post_setup", 20, 20, 6'b110000);

    // 100 back-to-back pixels, latency exactly 3
    for (int j = 0; j < 104; j++) begin
      @(negedge clk);
      if (j >= 3 && j < 103) begin
        chk("stream_v", 8'(color_valid_out), 8'd1);
        chk("stream_c", 8'(color_out), 8'(exp_q.pop_front()));
      end else begin
        chk("stream_idle_v", 8'(color_valid_out), 8'd0);
      end
      if (j < 100) begin
        px_valid_in = 1'b1;
        case (j % 3)
          0: begin px_x_in = 7'd20; px_y_in = 6'd20; exp_q.push_back(6'b110000); end
          1: begin px_x_in = 7'd60; px_y_in = 6'd30; exp_q.push_back(6'b000011); end
          default: begin px_x_in = 7'd10; px_y_in = 6'd10; exp_q.push_back(6'b110000); end
        endcase
      end else begin
        px_valid_in = 1'b0;
      end
    end

    // Reset with pixels in flight
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      px_valid_in = 1'b1; px_x_in = 7'd20; px_y_in = 6'd20;
    end
    chk("pre_rst_v", 8'(color_valid_out), 8'd1);
    chk("pre_rst_c", 8'(color_out), 8'(6'b110000));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 8'(color_valid_out), 8'd0);
    chk("mid_rst_c", 8'(color_out), 8'd0);
    px_valid_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    pix("after_rst", 20, 20, 6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/raster_core.md
Name: raster_core

Overview:
- Per-pixel triangle rasteriser directly downstream of the SPI register frontend.
- Snapshots the frontend's scene bundle (background, two polygons, screen enable) at each frame start. Tests every incoming pixel coordinate against both triangles using edge functions, resolves depth, and emits one 6-bit RRGGBB colour per pixel to the video output stage.
- Fully pipelined: one pixel per clock, fixed latency.

Parameters:
- XW, 7, polygon/pixel X coordinate width
- YW, 6, polygon/pixel Y coordinate width
- CW, 6, colour width (RRGGBB)
- DW, 3, per-polygon depth width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start_in  in  1  one-cycle pulse at start of each frame; captures scene snapshot
- px_valid_in  in  1  pixel coordinate valid this cycle
- px_x_in  in  XW  pixel X
- px_y_in  in  YW  pixel Y
- bg_color_in  in  CW  background colour
- poly_color_in  in  2*CW  polygon colours; poly i at [i*CW +: CW]
- v0_x_in, v1_x_in, v2_x_in  in  2*XW  vertex X; poly i at [i*XW +: XW]
- v0_y_in, v1_y_in, v2_y_in  in  2*YW  vertex Y; poly i at [i*YW +: YW]
- poly_depth_in  in  2*DW  depth; poly i at [i*DW +: DW]; smaller = closer
- en_screen_in  in  1  global display enable
- poly_enable_in  in  2  per-polygon enable
- color_out  out  CW  resolved pixel colour
- color_valid_out  out  1  color_out valid

Behaviour:
- Reset (async, rst_n low):
  - All shadow registers clear to 0, so en_screen=0 and polygons disabled.
  - Degenerate flags clear to 1.
  - Pipeline valids clear; color_out=0, color_valid_out=0.
  - Deassertion is sampled on clk. A reset mid-frame discards in-flight pixels; output stays black until the next frame_start_in.
- Snapshot:
  - On a clk edge with frame_start_in=1, all scene inputs are copied into shadow registers.
  - Scene inputs are ignored at all other times. Mid-frame changes have no visible effect until the next frame start.
- Setup (cycle after capture):
  - For each polygon, registers degen[i] = (E(v0,v1,v2) == 0), using shadow vertices.
  - A degenerate polygon is never drawn.
  - setup_busy is high in the frame_start_in cycle and the following cycle. Pixels accepted while setup_busy=1 complete normally with color_out=0.
- Edge function: E(a,b,p) = (p.x-a.x)*(b.y-a.y) - (p.y-a.y)*(b.x-a.x).
  - Operands are zero-extended, then differenced to signed XW+1 / YW+1 bits.
  - Products and result are signed, XW+YW+3 bits (16 at defaults). No overflow is possible.
- Pipeline, latency 3 (px_valid_in at cycle N -> color_valid_out at N+3):
  - S1: register px, valid, setup_busy.
  - S2: compute and register E01, E12, E20 for both polygons.
  - S3: hit[i] = poly_enable[i] & ~degen[i] & ((all three E >= 0) | (all three E <= 0)). Either winding is accepted; edges and vertices are inclusive.
  - Output register, colour select:
    - en_screen=0 or setup_busy: 0.
    - Both hit: the polygon with lower depth wins; on a depth tie, poly 0 wins.
    - Exactly one hit: that polygon's colour.
    - None hit: bg_color.
- color_valid_out mirrors px_valid_in delayed 3 cycles. Bubbles propagate; colour is held when not valid.
- No stall/backpressure; throughput is 1 pixel/clk.
- frame_start_in coincident with px_valid_in: that pixel is rendered as setup_busy (black).

Test Plan:
- Basic hit: reset; poly0 = (10,10),(50,10),(10,40), colour 6'b110000, depth 2, poly_enable=2'b01, bg=6'b000011, en_screen=1; frame_start; wait 2 cycles; pixel (20,20) -> 3 cycles later color_out=110000, valid=1. Pixel (60,30) -> 000011.
- Edge/winding: same scene, pixel (10,10) (vertex) -> 110000. Reverse vertex order (10,10),(10,40),(50,10) with pixel (20,20) -> 110000.
- Depth: poly1 = same triangle, colour 001100; vary depth and enable:
  - depth 1, enable 2'b11 -> pixel (20,20) gives 001100.
  - poly1 depth 2 (tie) -> 110000.
  - enable 2'b10 -> 001100.
- Degenerate/disable: poly0 = (5,5),(10,10),(15,15), pixel (10,10) -> bg 000011. en_screen=0 -> 000000 for every pixel.
- Snapshot and setup: change poly0 colour to 111111 mid-frame -> outputs stay 110000 until the next frame_start. Pixel driven in the frame_start cycle and the cycle after -> 000000 with valid=1. A streaming run of 100 back-to-back pixels -> 100 consecutive valids, latency exactly 3.
- Reset mid-stream: assert rst_n=0 with pixels in flight -> color_valid_out=0, color_out=0 immediately. After release, with no frame_start, pixels return 000000.
